axi_lite_arbiter: RTL and testbench
===================================

# axi_lite_arbiter

Round-robin arbiter that shares one `axi_lite_master` user interface between `NUM_REQ` independent requesters. Each requester posts a single read or write command and holds it until acknowledged. The arbiter serialises the commands: it grants one requester, issues a one-cycle request pulse to the master, waits for the master's done pulse, then returns the response and read data with a one-cycle ack. It sits between local bus clients (CPU shim, DMA descriptor fetch, debug port) and the master's `wr_*`/`rd_*` ports.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters; legal range 2..16.
- `ADDR_WIDTH`, 32, address width; must match the master.
- `DATA_WIDTH`, 32, data width; multiple of 8; must match the master.

Ports (requester `i` occupies slice `[i*W +: W]` of each packed bus):
- `aclk` in 1: clock.
- `aresetn` in 1: reset, asynchronous, active-low.
- `s_req` in NUM_REQ: command pending, held high until `s_ack[i]`.
- `s_we` in NUM_REQ: 1 = write, 0 = read; stable while `s_req[i]`.
- `s_addr` in NUM_REQ*ADDR_WIDTH: command address.
- `s_wdata` in NUM_REQ*DATA_WIDTH: write data.
- `s_wstrb` in NUM_REQ*DATA_WIDTH/8: write strobes.
- `s_ack` out NUM_REQ: one-hot, one-cycle completion pulse.
- `s_rdata` out DATA_WIDTH: read data; valid in the `s_ack` cycle (reads only).
- `s_resp` out 2: BRESP/RRESP; valid in the `s_ack` cycle.
- `busy` out 1: high in every state except IDLE.
- `grant_idx` out clog2(NUM_REQ): index of the current or last granted requester.
- `m_wr_req` out 1: connects to master `wr_req`.
- `m_wr_addr` out ADDR_WIDTH: connects to master `wr_addr`.
- `m_wr_data` out DATA_WIDTH: connects to master `wr_data`.
- `m_wr_strb` out DATA_WIDTH/8: connects to master `wr_strb`.
- `m_wr_done` in 1: from master `wr_done`.
- `m_wr_resp` in 2: from master `wr_resp`.
- `m_rd_req` out 1: connects to master `rd_req`.
- `m_rd_addr` out ADDR_WIDTH: connects to master `rd_addr`.
- `m_rd_done` in 1: from master `rd_done`.
- `m_rd_data` in DATA_WIDTH: from master `rd_data`.
- `m_rd_resp` in 2: from master `rd_resp`.

## Operation
- All outputs are registered. On reset:
  - state = IDLE, pointer = 0, `grant_idx` = 0.
  - `s_ack`, `m_wr_req`, `m_rd_req` and `busy` = 0.
  - All address, data, strobe, `s_rdata` and `s_resp` registers = 0.
- FSM states: IDLE, ISSUE, WAIT, ACK.
- **IDLE:** if `s_req` != 0, grant the first set bit found scanning upward from the pointer, wrapping at NUM_REQ-1 → 0.
  - Latch `grant_idx`, the command type and that requester's addr/wdata/wstrb into `m_*`.
  - For a write, load `m_wr_req` = 1; for a read, load `m_rd_req` = 1. Go to ISSUE.
  - If `s_req` = 0, stay in IDLE.
- **ISSUE:** `m_wr_req`/`m_rd_req` is high for exactly this cycle. Go to WAIT.
- **WAIT:** accept only the done pulse matching the latched type; a done of the other type is ignored.
  - On the matching done: capture `m_wr_resp`, or `m_rd_data` + `m_rd_resp`, into `s_resp`/`s_rdata`.
  - Set `s_ack[grant_idx]` and go to ACK.
- **ACK:** `s_ack` is high for exactly this cycle. Pointer ← (`grant_idx` + 1) mod NUM_REQ. Go to IDLE.
- Requester rule: deassert `s_req[i]` at the clock edge that ends its ack cycle. Because of the ACK state, the same request is never re-granted.
- `m_wr_addr`, `m_wr_data`, `m_wr_strb` and `m_rd_addr` hold their values until the next grant.
- On a write, `s_rdata` holds its previous value.
- No timeout: WAIT persists until the done pulse arrives.
- Fairness: a requester that keeps `s_req` high is serviced at most once per round while any other requester is pending.
- Reset mid-transaction (any state): immediate return to the reset values, and no ack is issued. The master shares `aresetn`.

## Timing
- Grant latency: `s_req` sampled in IDLE at cycle 0 → `m_*_req` high in cycle 1.
- Completion latency: `m_*_done` sampled high in cycle T → `s_ack` high in cycle T+1.
- Earliest re-grant: IDLE in cycle T+2, next `m_*_req` in cycle T+3.
- Minimum arbiter overhead per transaction: 3 cycles (ISSUE, ACK, IDLE) plus master and slave latency.
- With a zero-wait slave, a write completes with `s_ack` 6 cycles after `s_req` is first sampled. This holds when AW/W are accepted in the master's first cycle and BVALID is ready immediately.
- Simultaneous requests in IDLE: exactly one grant per IDLE cycle, chosen by round-robin order from the pointer.

## Test plan
- **Single write:** req2 writes addr 0x10, data 0xDEADBEEF, strb 0xF; slave returns OKAY.
  - `m_wr_req` pulses one cycle with those values.
  - `s_ack` = 0b0100 for one cycle, `s_resp` = 0.
- **Single read:** req0 reads 0x20; slave returns 0x12345678, SLVERR.
  - `s_ack[0]` pulses with `s_rdata` = 0x12345678 and `s_resp` = 2.
- **Round-robin:** after reset, all four requesters assert in the same cycle.
  - Acks in order 0, 1, 2, 3.
  - Each `m_*_req` is exactly one cycle, and no two transactions overlap.
- **Fairness:** req0 re-asserts immediately after every ack while req3 is pending.
  - Grant order is 0, 3, 0, 3; `grant_idx` matches each ack.
- **Stray done:** during a read WAIT, inject `m_wr_done`.
  - No ack is issued; the ack follows only the later `m_rd_done`.
- **Reset mid-WAIT:** assert `aresetn` = 0 while in WAIT.
  - All outputs return to 0 and `busy` = 0.
  - After release, a held req1 is granted first (pointer = 0, req0 idle).

Source files
------------

// File: rtl/axi_lite_arbiter.sv
// ---------------------------------------------------------------------------
// axi_lite_arbiter
//
// Round-robin arbiter that lets NUM_REQ local bus clients share a single
// axi_lite_master user interface. Each client posts one read or write command
// and holds it until it sees its ack. The arbiter grants one client at a
// time. It forwards the command to the master as a one-cycle request pulse
// and waits for the master's done pulse. It then hands the response and read
// data back together with a one-cycle ack.
//
// Ports (client i owns slice [i*W +: W] of every packed client bus):
//   aclk, aresetn         clock, asynchronous active-low reset
//   s_req/s_we            per-client command pending / write(1) or read(0)
//   s_addr/s_wdata/s_wstrb per-client command address, write data, strobes
//   s_ack                 one-hot, one-cycle completion pulse
//   s_rdata/s_resp        read data / BRESP-RRESP, valid in the ack cycle
//   busy                  high whenever the FSM is not in IDLE
//   grant_idx             index of the current or last granted client
//   m_wr_*                write command towards the master, plus its done/resp
//   m_rd_*                read command towards the master, plus its done/data/resp
// ---------------------------------------------------------------------------
module axi_lite_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   localparam int IDX_W     = $clog2(NUM_REQ),
   localparam int STRB_W    = DATA_WIDTH / 8
) (
   input  logic                          aclk,
   input  logic                          aresetn,

   input  logic [NUM_REQ-1:0]            s_req,
   input  logic [NUM_REQ-1:0]            s_we,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] s_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] s_wdata,
   input  logic [NUM_REQ*STRB_W-1:0]     s_wstrb,
   output logic [NUM_REQ-1:0]            s_ack,
   output logic [DATA_WIDTH-1:0]         s_rdata,
   output logic [1:0]                    s_resp,

   output logic                          busy,
   output logic [IDX_W-1:0]              grant_idx,

   output logic                          m_wr_req,
   output logic [ADDR_WIDTH-1:0]         m_wr_addr,
   output logic [DATA_WIDTH-1:0]         m_wr_data,
   output logic [STRB_W-1:0]             m_wr_strb,
   input  logic                          m_wr_done,
   input  logic [1:0]                    m_wr_resp,

   output logic                          m_rd_req,
   output logic [ADDR_WIDTH-1:0]         m_rd_addr,
   input  logic                          m_rd_done,
   input  logic [DATA_WIDTH-1:0]         m_rd_data,
   input  logic [1:0]                    m_rd_resp
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      ACK   = 2'd3
   } state_t;

   localparam logic [IDX_W:0]   NUM_REQ_W = (IDX_W+1)'(NUM_REQ);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

   state_t                  state_q,    state_d;
   logic [IDX_W-1:0]        ptr_q,      ptr_d;
   logic [IDX_W-1:0]        grantIdx_q, grantIdx_d;
   logic                    isWrite_q,  isWrite_d;
   logic                    mWrReq_q,   mWrReq_d;
   logic                    mRdReq_q,   mRdReq_d;
   logic [ADDR_WIDTH-1:0]   mWrAddr_q,  mWrAddr_d;
   logic [DATA_WIDTH-1:0]   mWrData_q,  mWrData_d;
   logic [STRB_W-1:0]       mWrStrb_q,  mWrStrb_d;
   logic [ADDR_WIDTH-1:0]   mRdAddr_q,  mRdAddr_d;
   logic [NUM_REQ-1:0]      sAck_q,     sAck_d;
   logic [DATA_WIDTH-1:0]   sRdata_q,   sRdata_d;
   logic [1:0]              sResp_q,    sResp_d;
   logic                    busy_q,     busy_d;

   logic [NUM_REQ-1:0]      reqRot;
   logic [IDX_W-1:0]        offset;
   logic [IDX_W:0]          pickSum;
   logic [IDX_W-1:0]        pick;
   logic                    anyReq;

   // Round-robin pick. The request vector is rotated so that the pointer
   // position lands on bit 0. The lowest set bit of the rotated vector is then
   // the distance from the pointer to the winner. Adding that distance back
   // onto the pointer, modulo NUM_REQ, gives the absolute index. This also
   // works when NUM_REQ is not a power of two.
   always_comb begin
      reqRot = NUM_REQ'({s_req, s_req} >> ptr_q);
      offset = '0;
      anyReq = 1'b0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (reqRot[k]) begin
            offset = IDX_W'(k);
            anyReq = 1'b1;
         end
      end
      pickSum = {1'b0, ptr_q} + {1'b0, offset};
      if (pickSum >= NUM_REQ_W) begin
         pick = IDX_W'(pickSum - NUM_REQ_W);
      end else begin
         pick = pickSum[IDX_W-1:0];
      end
   end

   // Next-state and next-output logic. Every output is a register, so this
   // block computes the values the outputs take in the following cycle. The
   // request and ack pulses default to low, which makes each of them last
   // exactly one cycle. The captured command and response fields default to
   // holding, so they stay stable until the next grant or completion.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      grantIdx_d = grantIdx_q;
      isWrite_d  = isWrite_q;
      mWrReq_d   = 1'b0;
      mRdReq_d   = 1'b0;
      mWrAddr_d  = mWrAddr_q;
      mWrData_d  = mWrData_q;
      mWrStrb_d  = mWrStrb_q;
      mRdAddr_d  = mRdAddr_q;
      sAck_d     = '0;
      sRdata_d   = sRdata_q;
      sResp_d    = sResp_q;

      unique case (state_q)
         IDLE: begin
            if (anyReq) begin
               grantIdx_d = pick;
               isWrite_d  = s_we[pick];
               mWrAddr_d  = s_addr[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH];
               mRdAddr_d  = s_addr[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH];
               mWrData_d  = s_wdata[int'(pick)*DATA_WIDTH +: DATA_WIDTH];
               mWrStrb_d  = s_wstrb[int'(pick)*STRB_W +: STRB_W];
               if (s_we[pick]) begin
                  mWrReq_d = 1'b1;
               end else begin
                  mRdReq_d = 1'b1;
               end
               state_d = ISSUE;
            end
         end

         ISSUE: begin
            state_d = WAIT;
         end

         // Only the done pulse that matches the command in flight counts.
         // A done pulse of the other type is ignored, so the command cannot
         // be completed with the wrong response.
         WAIT: begin
            if (isWrite_q && m_wr_done) begin
               sResp_d             = m_wr_resp;
               sAck_d[grantIdx_q]  = 1'b1;
               state_d             = ACK;
            end else if (!isWrite_q && m_rd_done) begin
               sResp_d             = m_rd_resp;
               sRdata_d            = m_rd_data;
               sAck_d[grantIdx_q]  = 1'b1;
               state_d             = ACK;
            end
         end

         // The pointer moves past the client that was just served. A client
         // that keeps requesting therefore waits until every other pending
         // client has had a turn. The ACK cycle also gives the client time to
         // drop its request before the arbiter looks at the requests again.
         ACK: begin
            if (grantIdx_q == LAST_IDX) begin
               ptr_d = '0;
            end else begin
               ptr_d = grantIdx_q + 1'b1;
            end
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and output registers. The master shares this reset, so when reset
   // is asserted mid-transaction everything simply goes back to idle and no
   // ack is issued.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         grantIdx_q <= '0;
         isWrite_q  <= 1'b0;
         mWrReq_q   <= 1'b0;
         mRdReq_q   <= 1'b0;
         mWrAddr_q  <= '0;
         mWrData_q  <= '0;
         mWrStrb_q  <= '0;
         mRdAddr_q  <= '0;
         sAck_q     <= '0;
         sRdata_q   <= '0;
         sResp_q    <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         grantIdx_q <= grantIdx_d;
         isWrite_q  <= isWrite_d;
         mWrReq_q   <= mWrReq_d;
         mRdReq_q   <= mRdReq_d;
         mWrAddr_q  <= mWrAddr_d;
         mWrData_q  <= mWrData_d;
         mWrStrb_q  <= mWrStrb_d;
         mRdAddr_q  <= mRdAddr_d;
         sAck_q     <= sAck_d;
         sRdata_q   <= sRdata_d;
         sResp_q    <= sResp_d;
         busy_q     <= busy_d;
      end
   end

   assign s_ack     = sAck_q;
   assign s_rdata   = sRdata_q;
   assign s_resp    = sResp_q;
   assign busy      = busy_q;
   assign grant_idx = grantIdx_q;
   assign m_wr_req  = mWrReq_q;
   assign m_wr_addr = mWrAddr_q;
   assign m_wr_data = mWrData_q;
   assign m_wr_strb = mWrStrb_q;
   assign m_rd_req  = mRdReq_q;
   assign m_rd_addr = mRdAddr_q;

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_arbiter
//
// Directed bench for axi_lite_arbiter with four clients and 32-bit buses.
// The bench plays the part of the master: it raises done pulses by hand.
// It steps through reset, a single write, a single read with a stray write
// done, round-robin order, fairness, and a reset during WAIT.
// ---------------------------------------------------------------------------
module tb_axi_lite_arbiter;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;

   logic              aclk;
   logic              aresetn;
   logic [N-1:0]      sReq;
   logic [N-1:0]      sWe;
   logic [N*AW-1:0]   sAddr;
   logic [N*DW-1:0]   sWdata;
   logic [N*SW-1:0]   sWstrb;
   logic [N-1:0]      sAck;
   logic [DW-1:0]     sRdata;
   logic [1:0]        sResp;
   logic              busy;
   logic [1:0]        grantIdx;
   logic              mWrReq;
   logic [AW-1:0]     mWrAddr;
   logic [DW-1:0]     mWrData;
   logic [SW-1:0]     mWrStrb;
   logic              mWrDone;
   logic [1:0]        mWrResp;
   logic              mRdReq;
   logic [AW-1:0]     mRdAddr;
   logic              mRdDone;
   logic [DW-1:0]     mRdData;
   logic [1:0]        mRdResp;

   int                passCount  = 0;
   int                totalCount = 0;
   logic [DW-1:0]     lastRdata  = '0;

   axi_lite_arbiter #(
      .NUM_REQ    (N),
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW)
   ) dut (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .s_req     (sReq),
      .s_we      (sWe),
      .s_addr    (sAddr),
      .s_wdata   (sWdata),
      .s_wstrb   (sWstrb),
      .s_ack     (sAck),
      .s_rdata   (sRdata),
      .s_resp    (sResp),
      .busy      (busy),
      .grant_idx (grantIdx),
      .m_wr_req  (mWrReq),
      .m_wr_addr (mWrAddr),
      .m_wr_data (mWrData),
      .m_wr_strb (mWrStrb),
      .m_wr_done (mWrDone),
      .m_wr_resp (mWrResp),
      .m_rd_req  (mRdReq),
      .m_rd_addr (mRdAddr),
      .m_rd_done (mRdDone),
      .m_rd_data (mRdData),
      .m_rd_resp (mRdResp)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   // Advance one clock and settle just after the rising edge.
   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   // Compare one observed value against the bench's expectation.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      totalCount++;
      assert (observed === expected) passCount++;
      else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
   endtask

   // Post a command from one client and raise its request.
   task automatic applyStimulus(input int idx, input logic we, input logic [AW-1:0] addr,
                                input logic [DW-1:0] wdata, input logic [SW-1:0] wstrb);
      sWe[idx]              = we;
      sAddr[idx*AW +: AW]   = addr;
      sWdata[idx*DW +: DW]  = wdata;
      sWstrb[idx*SW +: SW]  = wstrb;
      sReq[idx]             = 1'b1;
   endtask

   // Act as the master for one transaction. Wait, with a bound, for the
   // request pulse and check who was granted. Answer with a done pulse in the
   // first WAIT cycle, then check the ack and the IDLE cycle that follows.
   task automatic serveOne(input int idx, input logic isWr, input logic [AW-1:0] expAddr,
                           input logic [DW-1:0] rdVal, input logic [1:0] resp,
                           input logic holdReq);
      int n = 0;
      while (!(mWrReq || mRdReq) && n < 10) begin
         tick();
         n++;
      end
      if (!(mWrReq || mRdReq)) begin
         checkOutput("req_timeout", 64'(mWrReq | mRdReq), 64'(1));
         return;
      end
      checkOutput("grant_idx", 64'(grantIdx), 64'(idx));
      checkOutput("m_wr_req_type", 64'(mWrReq), 64'(isWr));
      checkOutput("m_rd_req_type", 64'(mRdReq), 64'(!isWr));
      if (isWr) checkOutput("m_wr_addr", 64'(mWrAddr), 64'(expAddr));
      else      checkOutput("m_rd_addr", 64'(mRdAddr), 64'(expAddr));
      tick();
      checkOutput("req_one_cycle", 64'(mWrReq | mRdReq), 64'(0));
      if (isWr) begin
         mWrDone = 1'b1;
         mWrResp = resp;
      end else begin
         mRdDone = 1'b1;
         mRdData = rdVal;
         mRdResp = resp;
         lastRdata = rdVal;
      end
      tick();
      mWrDone = 1'b0;
      mRdDone = 1'b0;
      checkOutput("s_ack", 64'(sAck), 64'(1) << idx);
      checkOutput("ack_grant_idx", 64'(grantIdx), 64'(idx));
      checkOutput("s_resp", 64'(sResp), 64'(resp));
      checkOutput("s_rdata", 64'(sRdata), 64'(lastRdata));
      if (!holdReq) sReq[idx] = 1'b0;
      tick();
      checkOutput("ack_one_cycle", 64'(sAck), 64'(0));
      checkOutput("idle_busy", 64'(busy), 64'(0));
   endtask

   // Directed test sequence.
   initial begin
      aresetn = 1'b0;
      sReq    = '0;
      sWe     = '0;
      sAddr   = '0;
      sWdata  = '0;
      sWstrb  = '0;
      mWrDone = 1'b0;
      mWrResp = 2'b00;
      mRdDone = 1'b0;
      mRdData = '0;
      mRdResp = 2'b00;

      // Reset values
      tick();
      tick();
      checkOutput("rst_s_ack", 64'(sAck), 64'(0));
      checkOutput("rst_busy", 64'(busy), 64'(0));
      checkOutput("rst_grant_idx", 64'(grantIdx), 64'(0));
      checkOutput("rst_m_wr_req", 64'(mWrReq), 64'(0));
      checkOutput("rst_m_rd_req", 64'(mRdReq), 64'(0));
      checkOutput("rst_s_rdata", 64'(sRdata), 64'(0));
      checkOutput("rst_s_resp", 64'(sResp), 64'(0));
      checkOutput("rst_m_wr_addr", 64'(mWrAddr), 64'(0));
      aresetn = 1'b1;

      // Single write from client 2, slave answers OKAY
      applyStimulus(2, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
      tick();
      checkOutput("wr_m_wr_req", 64'(mWrReq), 64'(1));
      checkOutput("wr_m_rd_req", 64'(mRdReq), 64'(0));
      checkOutput("wr_m_wr_addr", 64'(mWrAddr), 64'(32'h10));
      checkOutput("wr_m_wr_data", 64'(mWrData), 64'(32'hDEADBEEF));
      checkOutput("wr_m_wr_strb", 64'(mWrStrb), 64'(4'hF));
      checkOutput("wr_grant_idx", 64'(grantIdx), 64'(2));
      checkOutput("wr_busy", 64'(busy), 64'(1));
      tick();
      checkOutput("wr_req_pulse", 64'(mWrReq), 64'(0));
      checkOutput("wr_wait_ack", 64'(sAck), 64'(0));
      mWrDone = 1'b1;
      mWrResp = 2'b00;
      tick();
      mWrDone = 1'b0;
      checkOutput("wr_s_ack", 64'(sAck), 64'(4'b0100));
      checkOutput("wr_s_resp", 64'(sResp), 64'(0));
      sReq[2] = 1'b0;
      tick();
      checkOutput("wr_ack_pulse", 64'(sAck), 64'(0));
      checkOutput("wr_idle_busy", 64'(busy), 64'(0));

      // Single read from client 0, with a stray write done during WAIT
      applyStimulus(0, 1'b0, 32'h20, 32'h0, 4'h0);
      tick();
      checkOutput("rd_m_rd_req", 64'(mRdReq), 64'(1));
      checkOutput("rd_m_wr_req", 64'(mWrReq), 64'(0));
      checkOutput("rd_m_rd_addr", 64'(mRdAddr), 64'(32'h20));
      checkOutput("rd_grant_idx", 64'(grantIdx), 64'(0));
      tick();
      checkOutput("rd_req_pulse", 64'(mRdReq), 64'(0));
      mWrDone = 1'b1;
      mWrResp = 2'b01;
      tick();
      mWrDone = 1'b0;
      checkOutput("stray_no_ack", 64'(sAck), 64'(0));
      checkOutput("stray_busy", 64'(busy), 64'(1));
      mRdDone = 1'b1;
      mRdData = 32'h12345678;
      mRdResp = 2'b10;
      tick();
      mRdDone = 1'b0;
      checkOutput("rd_s_ack", 64'(sAck), 64'(4'b0001));
      checkOutput("rd_s_rdata", 64'(sRdata), 64'(32'h12345678));
      checkOutput("rd_s_resp", 64'(sResp), 64'(2));
      sReq[0] = 1'b0;
      tick();
      checkOutput("rd_ack_pulse", 64'(sAck), 64'(0));

      // Round-robin: reset, then all four clients request together
      aresetn = 1'b0;
      tick();
      checkOutput("rr_rst_s_rdata", 64'(sRdata), 64'(0));
      aresetn   = 1'b1;
      lastRdata = '0;
      applyStimulus(0, 1'b1, 32'h100, 32'hA0000000, 4'hF);
      applyStimulus(1, 1'b0, 32'h104, 32'h0, 4'h0);
      applyStimulus(2, 1'b1, 32'h108, 32'hA0000002, 4'h3);
      applyStimulus(3, 1'b0, 32'h10C, 32'h0, 4'h0);
      serveOne(0, 1'b1, 32'h100, 32'h0,        2'b00, 1'b0);
      serveOne(1, 1'b0, 32'h104, 32'hB0000001, 2'b00, 1'b0);
      serveOne(2, 1'b1, 32'h108, 32'h0,        2'b01, 1'b0);
      serveOne(3, 1'b0, 32'h10C, 32'hB0000003, 2'b11, 1'b0);

      // Fairness: clients 0 and 3 keep requesting; grants must alternate
      applyStimulus(0, 1'b1, 32'h200, 32'hC0000000, 4'hF);
      applyStimulus(3, 1'b0, 32'h300, 32'h0, 4'h0);
      serveOne(0, 1'b1, 32'h200, 32'h0,        2'b00, 1'b1);
      serveOne(3, 1'b0, 32'h300, 32'hC3C3C3C3, 2'b00, 1'b1);
      serveOne(0, 1'b1, 32'h200, 32'h0,        2'b00, 1'b1);
      serveOne(3, 1'b0, 32'h300, 32'h3C3C3C3C, 2'b00, 1'b0);
      serveOne(0, 1'b1, 32'h200, 32'h0,        2'b00, 1'b0);

      // Reset while a read from client 1 is waiting for the master
      applyStimulus(1, 1'b0, 32'h400, 32'h0, 4'h0);
      tick();
      checkOutput("mid_m_rd_req", 64'(mRdReq), 64'(1));
      checkOutput("mid_grant_idx", 64'(grantIdx), 64'(1));
      tick();
      checkOutput("mid_wait_busy", 64'(busy), 64'(1));
      aresetn = 1'b0;
      #1;
      checkOutput("mid_rst_busy", 64'(busy), 64'(0));
      checkOutput("mid_rst_s_ack", 64'(sAck), 64'(0));
      checkOutput("mid_rst_grant_idx", 64'(grantIdx), 64'(0));
      checkOutput("mid_rst_m_rd_req", 64'(mRdReq), 64'(0));
      checkOutput("mid_rst_m_rd_addr", 64'(mRdAddr), 64'(0));
      checkOutput("mid_rst_s_rdata", 64'(sRdata), 64'(0));
      checkOutput("mid_rst_s_resp", 64'(sResp), 64'(0));
      tick();
      checkOutput("mid_rst_no_ack", 64'(sAck), 64'(0));
      aresetn   = 1'b1;
      lastRdata = '0;
      serveOne(1, 1'b0, 32'h400, 32'h44444444, 2'b00, 1'b0);

      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule
